// File: rtl/serial_addsub.sv
// serial_addsub: digit-serial adder/subtractor, LSB first, DIGIT bits per clock.
// Define SERIAL_ADDSUB_OVF_EN to add the registered signed-overflow output ovf.
module serial_addsub #(
   parameter int WIDTH = 8,
   parameter int DIGIT = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             mode,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             cout
`ifdef SERIAL_ADDSUB_OVF_EN
   ,
   output logic             ovf
`endif
);
   localparam int N  = WIDTH / DIGIT;
   localparam int CW = N > 1 ? $clog2(N) : 1;

   if (WIDTH < 1 || DIGIT < 1 || WIDTH % DIGIT != 0) begin : g_bad_cfg
      $error("serial_addsub: WIDTH must be a positive multiple of DIGIT");
   end

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d, shifted;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             c_q, c_d, mode_q, mode_d, cout_q, cout_d;
   logic [DIGIT-1:0] sum;
   logic             c, accept, run, last;
`ifdef SERIAL_ADDSUB_OVF_EN
   logic             ovf_q, ovf_d, c_msb;
`endif

   // new result digit enters at the MSB end; after N shifts the word is in place
   if (WIDTH == DIGIT) begin : g_single
      assign shifted = sum;
   end else begin : g_multi
      assign shifted = {sum, res_q[WIDTH-1:DIGIT]};
   end

   always_comb begin
      c   = c_q;
      sum = '0;
`ifdef SERIAL_ADDSUB_OVF_EN
      c_msb = c_q;
`endif
      for (int i = 0; i < DIGIT; i++) begin
`ifdef SERIAL_ADDSUB_OVF_EN
         c_msb = c;
`endif
         sum[i] = a_q[i] ^ b_q[i] ^ c;
         c = mode_q ? ((~a_q[i] & b_q[i]) | (~(a_q[i] ^ b_q[i]) & c))
                    : ((a_q[i] & b_q[i]) | ((a_q[i] ^ b_q[i]) & c));
      end
      accept  = start && (state_q != RUN);
      run     = state_q == RUN;
      last    = cnt_q == CW'(N - 1);
      state_d = accept ? RUN : run ? (last ? DONE : RUN) : IDLE;
      a_d     = accept ? a : run ? a_q >> DIGIT : a_q;
      b_d     = accept ? b : run ? b_q >> DIGIT : b_q;
      c_d     = accept ? cin : run ? c : c_q;
      mode_d  = accept ? mode : mode_q;
      cnt_d   = accept ? '0 : run ? cnt_q + 1'b1 : cnt_q;
      res_d   = accept ? '0 : run ? shifted : res_q;
      cout_d  = (run && last) ? c : cout_q;
`ifdef SERIAL_ADDSUB_OVF_EN
      ovf_d   = (run && last) ? (c ^ c_msb) : ovf_q;
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         c_q     <= 1'b0;
         mode_q  <= 1'b0;
         cnt_q   <= '0;
         res_q   <= '0;
         cout_q  <= 1'b0;
`ifdef SERIAL_ADDSUB_OVF_EN
         ovf_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         c_q     <= c_d;
         mode_q  <= mode_d;
         cnt_q   <= cnt_d;
         res_q   <= res_d;
         cout_q  <= cout_d;
`ifdef SERIAL_ADDSUB_OVF_EN
         ovf_q   <= ovf_d;
`endif
      end
   end

   assign busy   = state_q == RUN;
   assign done   = state_q == DONE;
   assign result = res_q;
   assign cout   = cout_q;
`ifdef SERIAL_ADDSUB_OVF_EN
   assign ovf    = ovf_q;
`endif
endmodule

// File: tb/tb_serial_addsub.sv
// tb_serial_addsub: scoreboard bench for serial_addsub with DIGIT=1 and DIGIT=4 instances.
module tb_serial_addsub;
   localparam int W = 8;

   typedef struct {
      logic [W-1:0] r;
      logic         c;
      logic         o;
      int           at;
   } exp_t;

   logic         clk = 0, rst = 1, mode = 0, cin = 0, start1 = 0, start4 = 0;
   logic [W-1:0] a = '0, b = '0;
   logic         busy1, done1, cout1, busy4, done4, cout4;
   logic [W-1:0] res1, res4;
`ifdef SERIAL_ADDSUB_OVF_EN
   logic         ovf1, ovf4;
`endif
   int           errs = 0, checks = 0, cyc = 0;
   exp_t         q1[$], q4[$];

   serial_addsub #(.WIDTH(W), .DIGIT(1)) u_d1 (
      .clk(clk), .rst(rst), .start(start1), .mode(mode), .a(a), .b(b), .cin(cin),
      .busy(busy1), .done(done1), .result(res1), .cout(cout1)
`ifdef SERIAL_ADDSUB_OVF_EN
      , .ovf(ovf1)
`endif
   );

   serial_addsub #(.WIDTH(W), .DIGIT(4)) u_d4 (
      .clk(clk), .rst(rst), .start(start4), .mode(mode), .a(a), .b(b), .cin(cin),
      .busy(busy4), .done(done4), .result(res4), .cout(cout4)
`ifdef SERIAL_ADDSUB_OVF_EN
      , .ovf(ovf4)
`endif
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // reference: plain integer arithmetic on the operand values
   function automatic exp_t model(input logic m, input logic [W-1:0] x, input logic [W-1:0] y,
                                  input logic ci, input int at);
      exp_t e;
      int   s, ux, uy;
      ux = int'(x);
      uy = int'(y);
      s  = m ? int'($signed(x)) - int'($signed(y)) - int'(ci)
             : int'($signed(x)) + int'($signed(y)) + int'(ci);
      e.r  = m ? W'(ux - uy - int'(ci)) : W'(ux + uy + int'(ci));
      e.c  = m ? (ux < uy + int'(ci)) : (ux + uy + int'(ci) >= 2 ** W);
      e.o  = (s > 2 ** (W - 1) - 1) || (s < -(2 ** (W - 1)));
      e.at = at;
      return e;
   endfunction

   task automatic issue(input bit which, input logic m, input logic [W-1:0] x,
                        input logic [W-1:0] y, input logic ci);
      mode = m;
      a    = x;
      b    = y;
      cin  = ci;
      if (which) start4 = 1;
      else start1 = 1;
      @(posedge clk);
      #1;
      start1 = 0;
      start4 = 0;
      if (which) q4.push_back(model(m, x, y, ci, cyc + W / 4));
      else q1.push_back(model(m, x, y, ci, cyc + W));
   endtask

   task automatic wait_done(input bit which);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(which ? done4 : done1) && n < 40);
      if (!(which ? done4 : done1)) begin
         errs++;
         checks++;
         $display("FAIL timeout: no done from DIGIT=%0d instance within 40 cycles", which ? 4 : 1);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (done1) begin
         if (q1.size() == 0) chk("d1_spurious_done", 1, 0);
         else begin
            e = q1.pop_front();
            chk("d1_result", 32'(res1), 32'(e.r));
            chk("d1_cout", 32'(cout1), 32'(e.c));
            chk("d1_done_cycle", cyc, e.at);
            chk("d1_busy_at_done", 32'(busy1), 0);
`ifdef SERIAL_ADDSUB_OVF_EN
            chk("d1_ovf", 32'(ovf1), 32'(e.o));
`endif
         end
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (done4) begin
         if (q4.size() == 0) chk("d4_spurious_done", 1, 0);
         else begin
            e = q4.pop_front();
            chk("d4_result", 32'(res4), 32'(e.r));
            chk("d4_cout", 32'(cout4), 32'(e.c));
            chk("d4_done_cycle", cyc, e.at);
            chk("d4_busy_at_done", 32'(busy4), 0);
`ifdef SERIAL_ADDSUB_OVF_EN
            chk("d4_ovf", 32'(ovf4), 32'(e.o));
`endif
         end
      end
   end

   initial begin
      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy", 32'(busy1), 0);
      chk("rst_done", 32'(done1), 0);
      chk("rst_result", 32'(res1), 0);
      chk("rst_cout", 32'(cout1), 0);
      chk("rst_busy4", 32'(busy4), 0);
`ifdef SERIAL_ADDSUB_OVF_EN
      chk("rst_ovf", 32'(ovf1), 0);
`endif
      rst = 0;
      @(posedge clk);
      #1;
      issue(0, 1, 8'h05, 8'h03, 0);
      wait_done(0);
      issue(0, 1, 8'h00, 8'h01, 0);
      wait_done(0);
      issue(0, 0, 8'hFF, 8'h01, 1);
      wait_done(0);
      issue(1, 1, 8'h3C, 8'h5A, 0);
      wait_done(1);
      issue(0, 1, 8'h80, 8'h01, 0);
      wait_done(0);
      issue(0, 0, 8'h7F, 8'h01, 0);
      wait_done(0);
      issue(0, 0, 8'h10, 8'h20, 0);
      wait_done(0);
      // start during RUN must be ignored
      issue(0, 0, 8'h12, 8'h34, 0);
      repeat (3) @(posedge clk);
      #1;
      a = 8'hAA; b = 8'h55; mode = 1; cin = 1; start1 = 1;
      @(posedge clk);
      #1;
      start1 = 0;
      wait_done(0);
      // reset mid-operation aborts and clears outputs
      issue(0, 0, 8'hC3, 8'h5A, 1);
      repeat (4) @(posedge clk);
      #1;
      rst = 1;
      @(posedge clk);
      #1;
      q1.delete();
      chk("abort_busy", 32'(busy1), 0);
      chk("abort_done", 32'(done1), 0);
      chk("abort_result", 32'(res1), 0);
      chk("abort_cout", 32'(cout1), 0);
      rst = 0;
      @(posedge clk);
      #1;
      issue(0, 1, 8'h9E, 8'h2B, 1);
      wait_done(0);
      for (int i = 0; i < 30; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
         end
         issue(0, 1'($urandom), 8'($urandom), 8'($urandom), 1'($urandom));
         wait_done(0);
      end
      for (int i = 0; i < 20; i++) begin
         issue(1, 1'($urandom), 8'($urandom), 8'($urandom), 1'($urandom));
         wait_done(1);
      end
      repeat (4) @(posedge clk);
      #1;
      chk("q1_drained", 32'(q1.size()), 0);
      chk("q4_drained", 32'(q4.size()), 0);
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
